// File: rtl/modulo_debounce_botoes_if.sv
// Button bus between the raw pins and the debounce block.
//   btn_n     : raw pins, active-low (bit 0 = confirm, bit 1 = clear)
//   btn_level : debounced level, 1 = pressed
//   btn_pulse : one-cycle strobe per accepted press (and per repeat)
// The master modport is the side that drives the pins and consumes the
// conditioned outputs; the slave modport is the debounce block itself.
interface modulo_debounce_botoes_if;
    logic [1:0] btn_n;
    logic [1:0] btn_level;
    logic [1:0] btn_pulse;

    modport master (
        output btn_n,
        input  btn_level,
        input  btn_pulse
    );

    modport slave (
        input  btn_n,
        output btn_level,
        output btn_pulse
    );
endinterface

// File: rtl/modulo_debounce_botoes.sv
// Push-button conditioner for the game core: two independent channels,
// each a 2-flop synchronizer followed by a debounce FSM that emits a clean
// level and a registered one-cycle press pulse on clk.
//
// Optional feature: define DEBOUNCE_AUTOREPEAT_EN to add a per-channel
// auto-repeat counter that re-fires btn_pulse every REP_CYCLES cycles while
// a button stays in the pressed state. With the macro undefined no repeat
// counter exists and exactly one pulse is produced per accepted press.
module modulo_debounce_botoes #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned REP_CYCLES = 25000000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic                           clk,
    input  logic                           clr,
    modulo_debounce_botoes_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_REL_CHK   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam longint unsigned  CNT_MAX_NEEDED =
        (DEB_CYCLES > REP_CYCLES) ? longint'(DEB_CYCLES) : longint'(REP_CYCLES);

    // Reject configurations where the counter could wrap before the
    // terminal count is reached.
    if (DEB_CYCLES < 2 || REP_CYCLES < 2 || CNT_W < 1 || CNT_W > 62 ||
        (64'd1 << CNT_W) <= CNT_MAX_NEEDED) begin : g_param_check
        $error("modulo_debounce_botoes: invalid DEB_CYCLES/REP_CYCLES/CNT_W");
    end

    logic [1:0] w_level;
    logic [1:0] w_pulse;

    assign bus.btn_level = w_level;
    assign bus.btn_pulse = w_pulse;

    // Two identical channels with no shared state.
    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic [1:0]       r_sync;
        logic             w_s;
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             r_pulse;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_CYCLES - 1);
        logic [CNT_W-1:0] r_rep;
`endif

        // Two-flop synchronizer; resets to the released (high) pin level.
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_sync <= '1;
            end else begin
                r_sync <= {r_sync[0], bus.btn_n[g]};
            end
        end

        // Active-high pressed indication from the synchronized pin.
        assign w_s = ~r_sync[1];

        // Debounce FSM with registered level and pulse outputs; the
        // counter is cleared on every state entry so it can never wrap.
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_pulse <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                r_rep   <= '0;
`endif
            end else begin
                r_pulse <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_s) begin
                            r_state <= ST_PRESS_CHK;
                            r_cnt   <= '0;
                        end
                    end
                    ST_PRESS_CHK: begin
                        if (!w_s) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == DEB_LAST) begin
                            r_state <= ST_PRESSED;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_pulse <= 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                            r_rep   <= '0;
`endif
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_s) begin
                            r_state <= ST_REL_CHK;
                            r_cnt   <= '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                            r_rep   <= '0;
`endif
                        end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
                            if (r_rep == REP_LAST) begin
                                r_rep   <= '0;
                                r_pulse <= 1'b1;
                            end else begin
                                r_rep <= r_rep + CNT_ONE;
                            end
`endif
                        end
                    end
                    ST_REL_CHK: begin
                        if (w_s) begin
                            // Release was a glitch: back to pressed, no pulse.
                            r_state <= ST_PRESSED;
                            r_cnt   <= '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                            r_rep   <= '0;
`endif
                        end else if (r_cnt == DEB_LAST) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_level <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end
                endcase
            end
        end

        assign w_level[g] = r_level;
        assign w_pulse[g] = r_pulse;
    end

endmodule
